instr_fetch: RTL and testbench

- Fetch stage directly upstream of the multi-cycle `processor` execute core.
- Prefetches 16-bit instruction words from instruction memory into a small word queue.
- Presents one complete instruction per valid/ready handshake to the core. Two-word instructions (call 4'hC, jump 4'hD, jumpf 4'hE) are bundled with their following address word.
- Handles pc redirects from the core (taken jump/call/ret) by flushing the queue and discarding stale memory data.

---
 rtl/instr_fetch_pkg.sv | 41 ++++
 rtl/instr_fetch_queue.sv | 59 +++++
 rtl/instr_fetch.sv | 132 +++++++++++++
 tb/tb_instr_fetch.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch stage: word width, opcodes, FSM states.
// Latency: n/a (package).
// Backpressure: n/a (package).
package instr_fetch_pkg;

  localparam int WORD = 16;

  // Processor opcodes (ir[15:12]); only call/jump/jumpf carry an address word.
  localparam logic [3:0] OP_HALT  = 4'h0;
  localparam logic [3:0] OP_LOADI = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_ADD   = 4'h4;
  localparam logic [3:0] OP_SUB   = 4'h5;
  localparam logic [3:0] OP_AND   = 4'h6;
  localparam logic [3:0] OP_OR    = 4'h7;
  localparam logic [3:0] OP_XOR   = 4'h8;
  localparam logic [3:0] OP_SHIFT = 4'h9;
  localparam logic [3:0] OP_CMP   = 4'hA;
  localparam logic [3:0] OP_RET   = 4'hB;
  localparam logic [3:0] OP_CALL  = 4'hC;
  localparam logic [3:0] OP_JUMP  = 4'hD;
  localparam logic [3:0] OP_JUMPF = 4'hE;
  localparam logic [3:0] OP_NOP   = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [WORD-1:0] pc;
    logic [WORD-1:0] word;
  } qentry_t;

  function automatic logic is_two_word(input logic [3:0] op);
    return (op == OP_CALL) || (op == OP_JUMP) || (op == OP_JUMPF);
  endfunction

endpackage

// File: rtl/instr_fetch_queue.sv
// Circular buffer of {pc, word} feeding the instruction assembler.
// Latency: push visible at head one cycle later; heads are read combinationally.
// Backpressure: none internally; the fetch FSM never pushes when full, flush dominates.
module fetch_queue
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WORD-1:0]          push_pc,
  input  logic [WORD-1:0]          push_word,
  input  logic                     pop1,
  input  logic                     pop2,
  input  logic                     flush,
  output logic [WORD-1:0]          head0_pc,
  output logic [WORD-1:0]          head0_word,
  output logic [WORD-1:0]          head1_word,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  qentry_t          entries [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr_p1;
  logic [1:0]       pop_n;

  assign pop_n      = pop2 ? 2'd2 : (pop1 ? 2'd1 : 2'd0);
  assign rd_ptr_p1  = rd_ptr + AW'(1);
  assign head0_pc   = entries[rd_ptr].pc;
  assign head0_word = entries[rd_ptr].word;
  assign head1_word = entries[rd_ptr_p1].word;

  // Storage and pointers; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        entries[wr_ptr] <= '{pc: push_pc, word: push_word};
        wr_ptr          <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_ptr + AW'(pop_n);
      count  <= count + CW'(push) - CW'(pop_n);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: prefetches words into a queue and hands whole instructions to the core.
// Latency: first instruction valid two cycles after request issue with a zero-wait memory.
// Backpressure: ir_ready low lets the queue fill; requests stop when full or halted.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [WORD-1:0] RESET_PC = 16'h0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            halt,
  output logic            mem_req,
  output logic [WORD-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [WORD-1:0] mem_rdata,
  input  logic            redirect,
  input  logic [WORD-1:0] redirect_pc,
  output logic            ir_valid,
  input  logic            ir_ready,
  output logic [WORD-1:0] ir,
  output logic [WORD-1:0] ir_imm,
  output logic            ir_has_imm,
  output logic [WORD-1:0] ir_pc
);

  localparam int             CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  FULL = CW'(DEPTH);

  fetch_state_t    state, state_n;
  logic [WORD-1:0] fetch_pc, pc_n, addr_n;
  logic            req_n;
  logic            push, pop, pop1, pop2, has_imm;
  logic [WORD-1:0] head0_pc, head0_word, head1_word;
  logic [CW-1:0]   count;

  fetch_queue #(.DEPTH(DEPTH)) u_q (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_pc    (mem_addr),
    .push_word  (mem_rdata),
    .pop1       (pop1),
    .pop2       (pop2),
    .flush      (redirect),
    .head0_pc   (head0_pc),
    .head0_word (head0_word),
    .head1_word (head1_word),
    .count      (count)
  );

  assign has_imm    = is_two_word(head0_word[WORD-1 -: 4]);
  assign ir         = head0_word;
  assign ir_pc      = head0_pc;
  assign ir_has_imm = has_imm;
  assign ir_imm     = has_imm ? head1_word : '0;
  assign ir_valid   = has_imm ? (count >= CW'(2)) : (count >= CW'(1));
  assign pop        = ir_valid && ir_ready && !redirect;
  assign pop1       = pop && !has_imm;
  assign pop2       = pop && has_imm;

  // State, fetch pointer and the registered memory request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      state    <= state_n;
      fetch_pc <= pc_n;
      mem_req  <= req_n;
      mem_addr <= addr_n;
    end
  end

  // Next-state: request issue, push on ack, and redirect overriding everything.
  always_comb begin
    state_n = state;
    pc_n    = fetch_pc;
    req_n   = mem_req;
    addr_n  = mem_addr;
    push    = 1'b0;
    case (state)
      IDLE: begin
        if (!halt && (count < FULL)) begin
          req_n   = 1'b1;
          addr_n  = fetch_pc;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          push = 1'b1;
          pc_n = fetch_pc + WORD'(1);
          if (!halt && ((count + CW'(1)) < FULL)) begin
            req_n  = 1'b1;
            addr_n = fetch_pc + WORD'(1);
          end else begin
            req_n   = 1'b0;
            state_n = IDLE;
          end
        end
      end
      DRAIN: begin
        // Stale read completes here and is thrown away.
        if (mem_ack) begin
          req_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        req_n   = 1'b0;
        state_n = IDLE;
      end
    endcase
    if (redirect) begin
      push = 1'b0;
      pc_n = redirect_pc;
      if (mem_req && !mem_ack) begin
        // Read still in flight: keep the bus stable and wait it out.
        state_n = DRAIN;
        req_n   = 1'b1;
        addr_n  = mem_addr;
      end else begin
        state_n = IDLE;
        req_n   = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset, halt, mem_req, mem_ack, redirect, ir_valid, ir_ready, ir_has_imm;
  logic [15:0] mem_addr, mem_rdata, redirect_pc, ir, ir_imm, ir_pc;

  logic [15:0] mem [0:65535];
  logic [15:0] ack_q [$];
  int          lat = 0;
  int          cnt = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] a;

  always #5 clk = ~clk;

  instr_fetch #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .halt(halt),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir), .ir_imm(ir_imm),
    .ir_has_imm(ir_has_imm), .ir_pc(ir_pc)
  );

  // Memory responder: ack after 'lat' idle negedges, one read at a time, dropped on reset.
  always @(negedge clk) begin
    if (!reset) begin
      mem_ack = 1'b0;
      cnt     = 0;
    end else begin
      if (mem_ack) cnt = 0;
      mem_ack = 1'b0;
      if (mem_req) begin
        if (cnt >= lat) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
          ack_q.push_back(mem_addr);
        end else begin
          cnt++;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_redirect(input logic [15:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    tick();
    redirect    = 1'b0;
  endtask

  // Waits (bounded) for a valid instruction, checks it, and lets the handshake happen.
  task automatic expect_ir(input string tag, input logic [15:0] e_ir, input logic [15:0] e_imm,
                           input logic e_has, input logic [15:0] e_pc);
    int n = 0;
    while (!ir_valid && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, {31'd0, ir_valid}, 32'd1);
    chk({tag, "_ir"},    {16'd0, ir},       {16'd0, e_ir});
    chk({tag, "_imm"},   {16'd0, ir_imm},   {16'd0, e_imm});
    chk({tag, "_has"},   {31'd0, ir_has_imm}, {31'd0, e_has});
    chk({tag, "_pc"},    {16'd0, ir_pc},    {16'd0, e_pc});
    tick();
  endtask

  task automatic wait_ack(input string tag, output logic [15:0] addr);
    int n = 0;
    while (ack_q.size() == 0 && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_seen"}, {31'd0, (ack_q.size() != 0)}, 32'd1);
    addr = (ack_q.size() != 0) ? ack_q.pop_front() : 16'hxxxx;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!mem_req && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, {31'd0, mem_req}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h1000 | (i[15:0] & 16'h0FFF);
    mem[0] = 16'h1123; mem[1] = 16'h9105; mem[2] = 16'hC000; mem[3] = 16'h0040;
    reset = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    ir_ready = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0000;

    // Reset state
    repeat (3) tick();
    chk("rst_mem_req",  {31'd0, mem_req},  32'd0);
    chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
    chk("rst_ir",       {16'd0, ir},       32'd0);
    chk("rst_ir_pc",    {16'd0, ir_pc},    32'd0);
    chk("rst_ir_imm",   {16'd0, ir_imm},   32'd0);

    // Zero-wait stream; C000+0040 is one handshake, so pc 4 follows it
    lat = 0; ir_ready = 1'b1; reset = 1'b1;
    expect_ir("t1_a", 16'h1123, 16'h0000, 1'b0, 16'h0000);
    expect_ir("t1_b", 16'h9105, 16'h0000, 1'b0, 16'h0001);
    expect_ir("t1_c", 16'hC000, 16'h0040, 1'b1, 16'h0002);
    expect_ir("t1_d", 16'h1004, 16'h0000, 1'b0, 16'h0004);

    // Backpressure fill with 3-cycle memory, then one pop -> exactly one request
    ir_ready = 1'b0; lat = 3;
    pulse_redirect(16'h0100);
    repeat (40) tick();
    ack_q.delete();
    repeat (20) tick();
    chk("t2_full_no_ack", ack_q.size(), 32'd0);
    chk("t2_full_req",    {31'd0, mem_req},  32'd0);
    chk("t2_head_valid",  {31'd0, ir_valid}, 32'd1);
    chk("t2_head_ir",     {16'd0, ir},       32'h1100);
    chk("t2_head_pc",     {16'd0, ir_pc},    32'h0100);
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    repeat (20) tick();
    chk("t2_one_ack", ack_q.size(), 32'd1);
    a = (ack_q.size() != 0) ? ack_q[0] : 16'hxxxx;
    chk("t2_ack_addr",  {16'd0, a},       32'h0104);
    chk("t2_req_low",   {31'd0, mem_req}, 32'd0);
    chk("t2_next_pc",   {16'd0, ir_pc},   32'h0101);

    // Redirect while read of 0x0005 is outstanding
    lat = 8;
    pulse_redirect(16'h0005);
    wait_req("t3_issue");
    chk("t3_issue_addr", {16'd0, mem_addr}, 32'h0005);
    ack_q.delete();
    repeat (2) tick();
    pulse_redirect(16'h0040);
    chk("t3_drain_req",   {31'd0, mem_req},  32'd1);
    chk("t3_drain_addr",  {16'd0, mem_addr}, 32'h0005);
    chk("t3_drain_valid", {31'd0, ir_valid}, 32'd0);
    wait_ack("t3_ack0", a);
    chk("t3_ack0_addr", {16'd0, a}, 32'h0005);
    wait_ack("t3_ack1", a);
    chk("t3_ack1_addr", {16'd0, a}, 32'h0040);
    ir_ready = 1'b1;
    expect_ir("t3_ir", 16'h1040, 16'h0000, 1'b0, 16'h0040);

    // Redirect and handshake in the same cycle
    ir_ready = 1'b0; lat = 0;
    repeat (30) tick();
    chk("t4_pre_valid", {31'd0, ir_valid}, 32'd1);
    ir_ready = 1'b1;
    pulse_redirect(16'h0200);
    ir_ready = 1'b0;
    chk("t4_flushed_valid", {31'd0, ir_valid}, 32'd0);
    ir_ready = 1'b1;
    expect_ir("t4_ir", 16'h1200, 16'h0000, 1'b0, 16'h0200);

    // Two-word instruction at 0xFFFF wraps to 0x0000 for its immediate
    ir_ready = 1'b0;
    mem[16'hFFFF] = 16'hD000; mem[0] = 16'h1234;
    pulse_redirect(16'hFFFF);
    ir_ready = 1'b1;
    expect_ir("t5_jump", 16'hD000, 16'h1234, 1'b1, 16'hFFFF);
    expect_ir("t5_next", 16'h9105, 16'h0000, 1'b0, 16'h0001);

    // halt blocks new requests
    ir_ready = 1'b0; halt = 1'b1; lat = 8;
    pulse_redirect(16'h0300);
    repeat (20) tick();
    chk("t6_halt_req",   {31'd0, mem_req},  32'd0);
    chk("t6_halt_valid", {31'd0, ir_valid}, 32'd0);
    halt = 1'b0;
    wait_req("t6_issue");
    chk("t6_issue_addr", {16'd0, mem_addr}, 32'h0300);

    // Reset in the middle of an outstanding read
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("t7_rst_req",   {31'd0, mem_req},  32'd0);
    chk("t7_rst_valid", {31'd0, ir_valid}, 32'd0);
    repeat (2) tick();
    chk("t7_rst_req2",  {31'd0, mem_req},  32'd0);
    chk("t7_rst_ir",    {16'd0, ir},       32'd0);
    ack_q.delete();
    reset = 1'b1;
    wait_req("t7_post");
    chk("t7_post_addr", {16'd0, mem_addr}, 32'h0000);
    wait_ack("t7_ack", a);
    chk("t7_ack_addr", {16'd0, a}, 32'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
